// File: rtl/cm0_mtx_pkg.sv
// Shared AHB encodings and types for the Cortex-M0 bus-matrix input stage.
package cm0_mtx_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'b00,
    ERR1     = 2'b01,
    ERR2     = 2'b10
  } err_state_e;

  // Address-phase bundle captured when the output stage cannot take a transfer.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] auser;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [3:0]  master;
    logic        mastlock;
  } ahb_ctrl_t;

endpackage

// File: rtl/cm0_mtx_dflt_slv.sv
// Default slave: two-cycle AHB ERROR response for transfers to unmapped addresses.
module cm0_mtx_dflt_slv
  import cm0_mtx_pkg::*;
(
  input  logic HCLK,
  input  logic HRESET,
  input  logic trigger,
  output logic HREADYOUT,
  output logic HRESP
);

  err_state_e state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ERR_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
    end else begin
      case (state)
        ERR_IDLE: begin
          if (trigger) begin
            state     <= ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
          end
        end
        ERR1: begin
          state     <= ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        ERR2: begin
          state     <= ERR_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
        end
        default: begin
          state     <= ERR_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/cm0_mtx_in_stage.sv
// Port-0 input stage of the single-output AHB matrix: decode, hold, and
// HREADY/HRESP generation toward the master.
module cm0_mtx_in_stage
  import cm0_mtx_pkg::*;
#(
  parameter logic [31:0] REGION_BASE = 32'h0000_0000,
  parameter logic [31:0] REGION_MASK = 32'hE000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [31:0] HAUSERS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic [3:0]  HMASTERS,
  input  logic        HMASTLOCKS,
  input  logic [31:0] HWDATAS,
  input  logic [31:0] HWUSERS,
  input  logic        HREADYS,
  output logic        HREADYOUTS,
  output logic        HRESPS,
  output logic        sel_op0,
  output logic [31:0] addr_op0,
  output logic [31:0] auser_op0,
  output logic [1:0]  trans_op0,
  output logic        write_op0,
  output logic [2:0]  size_op0,
  output logic [2:0]  burst_op0,
  output logic [3:0]  prot_op0,
  output logic [3:0]  master_op0,
  output logic        mastlock_op0,
  output logic [31:0] wdata_op0,
  output logic [31:0] wuser_op0,
  output logic        held_tran_op0,
  input  logic        active_op0,
  input  logic        HREADYMUXM,
  input  logic        HRESPM
);

  logic      new_tran;
  logic      mapped;
  logic      accept;
  logic      pend;
  logic      dphase;
  logic      dflt_ready;
  logic      dflt_resp;
  ahb_ctrl_t live_ctrl;
  ahb_ctrl_t held_ctrl;
  ahb_ctrl_t out_ctrl;

  assign new_tran = HSELS & HREADYS & HTRANSS[1];
  assign mapped   = ((HADDRS & REGION_MASK) == REGION_BASE);
  assign accept   = active_op0 & HREADYMUXM;

  assign live_ctrl = '{
    addr:     HADDRS,
    auser:    HAUSERS,
    trans:    HTRANSS,
    write:    HWRITES,
    size:     HSIZES,
    burst:    HBURSTS,
    prot:     HPROTS,
    master:   HMASTERS,
    mastlock: HMASTLOCKS
  };

  // pend cannot coincide with new_tran because HREADYOUTS is low while pending.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend      <= 1'b0;
      dphase    <= 1'b0;
      held_ctrl <= '0;
    end else begin
      if (new_tran && mapped && !accept) begin
        pend      <= 1'b1;
        held_ctrl <= live_ctrl;
      end else if (accept) begin
        pend <= 1'b0;
      end

      if ((new_tran && mapped && accept) || (pend && accept))
        dphase <= 1'b1;
      else if (HREADYMUXM)
        dphase <= 1'b0;
    end
  end

  assign out_ctrl      = pend ? held_ctrl : live_ctrl;
  assign sel_op0       = pend | (HSELS & mapped);
  assign addr_op0      = out_ctrl.addr;
  assign auser_op0     = out_ctrl.auser;
  assign trans_op0     = out_ctrl.trans;
  assign write_op0     = out_ctrl.write;
  assign size_op0      = out_ctrl.size;
  assign burst_op0     = out_ctrl.burst;
  assign prot_op0      = out_ctrl.prot;
  assign master_op0    = out_ctrl.master;
  assign mastlock_op0  = out_ctrl.mastlock;
  assign wdata_op0     = HWDATAS;
  assign wuser_op0     = HWUSERS;
  assign held_tran_op0 = pend | (new_tran & mapped);

  cm0_mtx_dflt_slv u_dflt_slv (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .trigger   (new_tran & ~mapped),
    .HREADYOUT (dflt_ready),
    .HRESP     (dflt_resp)
  );

  // The default slave reports ERROR exactly while it is in ERR1/ERR2,
  // so its HRESP doubles as the "error response in progress" flag.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = HRESP_OKAY;
    if (dflt_resp) begin
      HREADYOUTS = dflt_ready;
      HRESPS     = HRESP_ERROR;
    end else if (pend) begin
      HREADYOUTS = 1'b0;
    end else if (dphase) begin
      HREADYOUTS = HREADYMUXM;
      HRESPS     = HRESPM;
    end
  end

endmodule

// File: tb/tb_cm0_mtx_in_stage.sv
// Directed self-checking bench for cm0_mtx_in_stage.
module tb_cm0_mtx_in_stage;
  import cm0_mtx_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSELS;
  logic [31:0] HADDRS, HAUSERS, HWDATAS, HWUSERS;
  logic [1:0]  HTRANSS;
  logic        HWRITES, HMASTLOCKS, HREADYS;
  logic [2:0]  HSIZES, HBURSTS;
  logic [3:0]  HPROTS, HMASTERS;
  logic        HREADYOUTS, HRESPS;
  logic        sel_op0, write_op0, mastlock_op0, held_tran_op0;
  logic [31:0] addr_op0, auser_op0, wdata_op0, wuser_op0;
  logic [1:0]  trans_op0;
  logic [2:0]  size_op0, burst_op0;
  logic [3:0]  prot_op0, master_op0;
  logic        active_op0, HREADYMUXM, HRESPM;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 HCLK = ~HCLK;

  cm0_mtx_in_stage dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
    .HAUSERS(HAUSERS), .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES),
    .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTERS(HMASTERS),
    .HMASTLOCKS(HMASTLOCKS), .HWDATAS(HWDATAS), .HWUSERS(HWUSERS),
    .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .sel_op0(sel_op0), .addr_op0(addr_op0), .auser_op0(auser_op0),
    .trans_op0(trans_op0), .write_op0(write_op0), .size_op0(size_op0),
    .burst_op0(burst_op0), .prot_op0(prot_op0), .master_op0(master_op0),
    .mastlock_op0(mastlock_op0), .wdata_op0(wdata_op0), .wuser_op0(wuser_op0),
    .held_tran_op0(held_tran_op0), .active_op0(active_op0),
    .HREADYMUXM(HREADYMUXM), .HRESPM(HRESPM)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks happen 1ns later.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic bus_idle();
    HSELS      = 1'b0;
    HTRANSS    = HTRANS_IDLE;
    HREADYS    = 1'b1;
    HMASTLOCKS = 1'b0;
  endtask

  task automatic start_tran(input logic [31:0] addr, input logic wr, input logic lock);
    HSELS      = 1'b1;
    HTRANSS    = HTRANS_NONSEQ;
    HADDRS     = addr;
    HWRITES    = wr;
    HMASTLOCKS = lock;
    HREADYS    = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESET = 1'b1;
    HADDRS = 32'h0; HAUSERS = 32'h0; HWDATAS = 32'h0; HWUSERS = 32'h0;
    HWRITES = 1'b0; HSIZES = 3'd0; HBURSTS = 3'd0; HPROTS = 4'd0; HMASTERS = 4'd0;
    active_op0 = 1'b1; HREADYMUXM = 1'b1; HRESPM = 1'b0;
    bus_idle();
    tick(); tick();
    HRESET = 1'b0;
    settle();
    check("rst_hreadyouts", HREADYOUTS, 1);
    check("rst_hresps", HRESPS, 0);
    check("rst_held_tran", held_tran_op0, 0);
    check("rst_sel", sel_op0, 0);

    // 1: accepted in the same cycle, no added latency.
    tick();
    start_tran(32'h0000_0100, 1'b0, 1'b0);
    HWDATAS = 32'hCAFE_F00D;
    settle();
    check("t1_held_tran", held_tran_op0, 1);
    check("t1_addr", addr_op0, 32'h100);
    check("t1_sel", sel_op0, 1);
    check("t1_ready", HREADYOUTS, 1);
    check("t1_wdata", wdata_op0, 32'hCAFE_F00D);
    tick();
    bus_idle();
    settle();
    check("t1_dphase_ready", HREADYOUTS, 1);
    check("t1_held_after", held_tran_op0, 0);

    // 2: output stage busy for three cycles; request held.
    tick();
    start_tran(32'h0000_0200, 1'b0, 1'b0);
    active_op0 = 1'b0;
    settle();
    check("t2_req_cycle0", held_tran_op0, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      bus_idle();
      HREADYS = 1'b0;
      HADDRS  = 32'h1234_0000 + i;
      if (i == 3) active_op0 = 1'b1;
      settle();
      check($sformatf("t2_ready_c%0d", i), HREADYOUTS, 0);
      check($sformatf("t2_addr_c%0d", i), addr_op0, 32'h200);
      check($sformatf("t2_held_c%0d", i), held_tran_op0, 1);
      check($sformatf("t2_trans_c%0d", i), trans_op0, HTRANS_NONSEQ);
      check($sformatf("t2_sel_c%0d", i), sel_op0, 1);
    end
    tick();
    HREADYS = 1'b1;
    settle();
    check("t2_pend_clear_ready", HREADYOUTS, 1);
    check("t2_pend_clear_held", held_tran_op0, 0);
    check("t2_pass_addr", addr_op0, 32'h1234_0003);

    // 3: unmapped address gets a two-cycle ERROR.
    tick();
    start_tran(32'h4000_0000, 1'b0, 1'b0);
    settle();
    check("t3_held_c0", held_tran_op0, 0);
    check("t3_sel_c0", sel_op0, 0);
    tick();
    bus_idle();
    HREADYS = 1'b0;
    settle();
    check("t3_ready_c1", HREADYOUTS, 0);
    check("t3_resp_c1", HRESPS, 1);
    check("t3_held_c1", held_tran_op0, 0);
    tick();
    HREADYS = 1'b1;
    settle();
    check("t3_ready_c2", HREADYOUTS, 1);
    check("t3_resp_c2", HRESPS, 1);
    check("t3_held_c2", held_tran_op0, 0);
    tick();
    settle();
    check("t3_resp_c3", HRESPS, 0);

    // 4: accepted read, slave stretches two cycles and answers ERROR.
    tick();
    start_tran(32'h0000_0400, 1'b0, 1'b0);
    tick();
    bus_idle();
    HREADYS = 1'b0;
    HREADYMUXM = 1'b0;
    HRESPM = 1'b1;
    settle();
    check("t4_ready_w1", HREADYOUTS, 0);
    check("t4_resp_w1", HRESPS, 1);
    tick();
    settle();
    check("t4_ready_w2", HREADYOUTS, 0);
    tick();
    HREADYMUXM = 1'b1;
    HREADYS = 1'b1;
    settle();
    check("t4_ready_done", HREADYOUTS, 1);
    check("t4_resp_done", HRESPS, 1);
    tick();
    HRESPM = 1'b0;
    settle();
    check("t4_resp_after", HRESPS, 0);

    // 5: locked transfer held while master drops HMASTLOCKS.
    tick();
    start_tran(32'h0000_0500, 1'b1, 1'b1);
    HSIZES = 3'd2; HMASTERS = 4'd5;
    active_op0 = 1'b0;
    tick();
    bus_idle();
    HREADYS = 1'b0;
    HMASTERS = 4'd0; HWRITES = 1'b0; HSIZES = 3'd0;
    settle();
    check("t5_lock_h1", mastlock_op0, 1);
    check("t5_write_h1", write_op0, 1);
    check("t5_size_h1", size_op0, 2);
    check("t5_master_h1", master_op0, 5);
    tick();
    active_op0 = 1'b1;
    settle();
    check("t5_lock_h2", mastlock_op0, 1);
    tick();
    HREADYS = 1'b1;
    settle();
    check("t5_lock_released", mastlock_op0, 0);
    check("t5_ready_after", HREADYOUTS, 1);

    // BUSY: not a request, but still visible on trans_op0.
    tick();
    HSELS = 1'b1;
    HTRANSS = HTRANS_BUSY;
    HADDRS = 32'h0000_0700;
    settle();
    check("busy_held", held_tran_op0, 0);
    check("busy_trans", trans_op0, HTRANS_BUSY);
    check("busy_ready", HREADYOUTS, 1);

    // 6: reset while a request is pending.
    tick();
    start_tran(32'h0000_0600, 1'b0, 1'b0);
    active_op0 = 1'b0;
    tick();
    bus_idle();
    HREADYS = 1'b0;
    HADDRS = 32'h0000_0ABC;
    settle();
    check("t6_pend_ready", HREADYOUTS, 0);
    HRESET = 1'b1;
    tick();
    settle();
    check("t6_rst_ready", HREADYOUTS, 1);
    check("t6_rst_held", held_tran_op0, 0);
    check("t6_rst_addr", addr_op0, 32'h0000_0ABC);
    HRESET = 1'b0;
    active_op0 = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cm0_mtx_in_stage.md
Name: cm0_mtx_in_stage

Overview:
Port-0 input stage of the single-output Cortex-M0 AHB bus matrix. It sits between the master-side AHB slave interface and the output stage. It decodes the address against one mapped region. It captures address/control into a holding register whenever the output stage cannot take a transfer this cycle, and presents it as a pending request (held_tran_op0). It stretches HREADYOUTS to the master and returns a two-cycle ERROR for unmapped addresses through an internal default slave.

Parameters:
REGION_BASE, 32'h0000_0000, base of the mapped region.
REGION_MASK, 32'hE000_0000, address bits compared against REGION_BASE; a match means mapped.

Ports:
HCLK in 1 AHB system clock
HRESET in 1 synchronous active-high reset
HSELS in 1 master-side select
HADDRS in 32 address
HAUSERS in 32 user address
HTRANSS in 2 transfer type
HWRITES in 1 direction
HSIZES in 3 size
HBURSTS in 3 burst
HPROTS in 4 protection
HMASTERS in 4 master ID
HMASTLOCKS in 1 lock
HWDATAS in 32 write data
HWUSERS in 32 write user
HREADYS in 1 master-bus HREADY
HREADYOUTS out 1 ready to master
HRESPS out 1 response to master (0 OKAY, 1 ERROR)
sel_op0 out 1 / addr_op0 out 32 / auser_op0 out 32 / trans_op0 out 2 / write_op0 out 1 / size_op0 out 3 / burst_op0 out 3 / prot_op0 out 4 / master_op0 out 4 / mastlock_op0 out 1: address/control to output stage
wdata_op0 out 32 / wuser_op0 out 32: write data to output stage (pass-through of HWDATAS/HWUSERS)
held_tran_op0 out 1 transfer request to output stage
active_op0 in 1 output stage has granted this port
HREADYMUXM in 1 output-stage transfer-done
HRESPM in 1 slave response

Behaviour:
- Single clock HCLK. HRESET is synchronous and active-high, sampled on posedge HCLK.
- Reset values: HREADYOUTS=1, HRESPS=0, held_tran_op0=0. The holding register is all zero. pend, dphase and the error FSM go to IDLE.
- new_tran = HSELS & HREADYS & HTRANSS[1].
- mapped = ((HADDRS & REGION_MASK) == REGION_BASE).
- accept = active_op0 & HREADYMUXM.
- Holding register: loaded with all address/control inputs on new_tran & mapped & ~accept. Sets pend=1.
- pend clears on accept.
- While pend=1, a new_tran is impossible, because HREADYOUTS=0.
- Output mux:
  - pend=1: op0 outputs come from the holding register; sel_op0=1; trans_op0=held HTRANS.
  - pend=0: op0 outputs are driven combinationally from the master inputs; sel_op0 = HSELS & mapped.
- held_tran_op0 = pend | (new_tran & mapped).
- Zero added latency when the output stage accepts in the same cycle.
- dphase: set on (new_tran & mapped & accept) or (pend & accept). Cleared when HREADYMUXM=1 with no new acceptance.
- HREADYOUTS priority:
  1. Error FSM in ERR1 gives 0; ERR2 gives 1.
  2. pend gives 0.
  3. dphase gives HREADYMUXM.
  4. Otherwise 1.
- HRESPS: 1 in ERR1 and ERR2. Otherwise HRESPM when dphase, else 0.
- Error FSM states: IDLE→ERR1 on new_tran & ~mapped; ERR1→ERR2 unconditionally; ERR2→IDLE.
  - An unmapped transfer never asserts held_tran_op0 or sel_op0.
- IDLE/BUSY transfers: OKAY, zero wait, not forwarded as requests. BUSY still drives trans_op0 when pend=0.
- mastlock_op0 reflects the held value while pend=1, so the output-stage lock tracking never sees a gap.
- Reset mid-pend: pend, dphase and the FSM clear on the next edge; HREADYOUTS=1 the cycle after.

Decomposition:
- Package cm0_mtx_pkg: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HRESP_OKAY/HRESP_ERROR, error-FSM state encodings.
- Sub-module cm0_mtx_dflt_slv: the three-state error FSM. Inputs: HCLK, HRESET, trigger. Outputs: HREADYOUT, HRESP.

Test Plan:
1. Mapped NONSEQ, HADDRS=0x0000_0100, active_op0=1, HREADYMUXM=1 → held_tran_op0=1 and addr_op0=0x100 the same cycle; pend stays 0; HREADYOUTS=1.
2. Mapped NONSEQ to 0x0000_0200 with active_op0=0 for 3 cycles → pend=1 and HREADYOUTS=0 for 3 cycles; addr_op0 holds 0x200 while HADDRS changes; pend clears on the accept cycle.
3. Unmapped NONSEQ to 0x4000_0000 → cycle+1: HREADYOUTS=0, HRESPS=1; cycle+2: HREADYOUTS=1, HRESPS=1; held_tran_op0 stays 0 throughout.
4. Accepted read, then HREADYMUXM=0 for 2 cycles and HRESPM=1 → HREADYOUTS=0 for 2 cycles, then 1; HRESPS follows HRESPM.
5. Locked NONSEQ (HMASTLOCKS=1) held 2 cycles, master drops HMASTLOCKS → mastlock_op0=1 until accept.
6. HRESET=1 asserted while pend=1 → next edge: HREADYOUTS=1, held_tran_op0=0, addr_op0 = HADDRS passthrough.
